// File: rtl/adex_pkg.sv
// Shared definitions for the AdEx neuron array: config field map, FSM states,
// default Q8.8 constants and the saturation helper.
package adex_pkg;

  localparam logic [2:0] F_VT     = 3'd0;
  localparam logic [2:0] F_VRESET = 3'd1;
  localparam logic [2:0] F_IBIAS  = 3'd2;
  localparam logic [2:0] F_B      = 3'd3;
  localparam logic [2:0] F_A      = 3'd4;
  localparam logic [2:0] F_TAUW   = 3'd5;
  localparam logic [2:0] F_V      = 3'd6;
  localparam logic [2:0] F_W      = 3'd7;

  localparam logic [15:0] Q_EL     = 16'hBA00;
  localparam logic [15:0] Q_VPEAK  = 16'h0000;
  localparam logic [15:0] Q_VT     = 16'hCE00;
  localparam logic [15:0] Q_VRESET = 16'hBF00;
  localparam logic [15:0] Q_DELTAT = 16'h0200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } adex_state_e;

  // Clamp x to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) begin
      sat = hi;
    end else if (x < lo) begin
      sat = lo;
    end else begin
      sat = x;
    end
  endfunction

endpackage

// File: rtl/adex_update_core.sv
// Combinational single-neuron AdEx step: computes next V, next w and the spike
// flag from one neuron's parameters and state, using shifts only.
module adex_update_core
  import adex_pkg::*;
#(
  parameter int            DW      = 16,
  parameter int            FRAC    = 8,
  parameter logic [DW-1:0] EL      = Q_EL,
  parameter logic [DW-1:0] VPEAK   = Q_VPEAK,
  parameter logic [DW-1:0] DELTAT  = Q_DELTAT,
  parameter int            LEAK_SH = 4,
  parameter int            DT_SH   = 2
) (
  input  logic [DW-1:0] vt,
  input  logic [DW-1:0] vreset,
  input  logic [DW-1:0] ibias,
  input  logic [DW-1:0] b,
  input  logic [7:0]    a,
  input  logic [3:0]    tauw_sh,
  input  logic [DW-1:0] v,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] v_next,
  output logic [DW-1:0] w_next,
  output logic          spike
);

  localparam int XW = DW + 8;

  function automatic logic signed [XW-1:0] ext(input logic [DW-1:0] x);
    ext = XW'($signed(x));
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [XW-1:0] x);
    clamp = DW'(sat(64'(x), DW));
  endfunction

  logic signed [XW-1:0] v_x_s, w_x_s, leak_s, d_s, dsh_s, expt_s, sum_s, dv_s, at_s;
  logic [2:0]           esh_s;

  // One integration step; the exponential term's shift is capped at 7.
  always_comb begin
    v_x_s  = ext(v);
    w_x_s  = ext(w);
    leak_s = (ext(EL) - v_x_s) >>> LEAK_SH;
    d_s    = v_x_s - ext(vt);
    dsh_s  = d_s >>> FRAC;
    if (dsh_s[XW-1:3] != {(XW-3){1'b0}}) begin
      esh_s = 3'd7;
    end else begin
      esh_s = dsh_s[2:0];
    end
    if (d_s[XW-1]) begin
      expt_s = {XW{1'b0}};
    end else begin
      expt_s = ext(DELTAT) <<< esh_s;
    end
    sum_s = leak_s + expt_s + ext(ibias) - w_x_s;
    dv_s  = v_x_s - ext(EL);
    at_s  = (dv_s * $signed({{(XW-8){1'b0}}, a})) >>> 8;
    if ($signed(v) >= $signed(VPEAK)) begin
      spike  = 1'b1;
      v_next = vreset;
      w_next = clamp(w_x_s + ext(b));
    end else begin
      spike  = 1'b0;
      v_next = clamp(v_x_s + (sum_s >>> DT_SH));
      w_next = clamp(w_x_s + ((at_s - w_x_s) >>> tauw_sh));
    end
  end

endmodule

// File: rtl/adex_neuron_array.sv
// Time-multiplexed array of N AdEx neurons: sweep FSM, per-neuron register
// file, configuration write port and registered monitor mux.
module adex_neuron_array
  import adex_pkg::*;
#(
  parameter int            N           = 4,
  parameter int            DW          = 16,
  parameter int            FRAC        = 8,
  parameter logic [DW-1:0] EL          = Q_EL,
  parameter logic [DW-1:0] VPEAK       = Q_VPEAK,
  parameter logic [DW-1:0] DELTAT      = Q_DELTAT,
  parameter int            LEAK_SH     = 4,
  parameter int            DT_SH       = 2,
  parameter logic [DW-1:0] VT_INIT     = Q_VT,
  parameter logic [DW-1:0] VRESET_INIT = Q_VRESET,
  parameter logic [7:0]    A_INIT      = 8'd0,
  parameter logic [DW-1:0] B_INIT      = {DW{1'b0}},
  parameter logic [3:0]    TAUW_INIT   = 4'd6,
  localparam int           NW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [NW+2:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [N-1:0]  spike,
  output logic          spike_valid,
  output logic          busy,
  output logic          overrun,
  input  logic [NW-1:0] mon_sel,
  input  logic          mon_w,
  output logic [DW-1:0] mon_data
);

  localparam logic [NW:0] N_L = (NW + 1)'(N);

  adex_state_e   state_r, state_nx_s;
  logic [NW-1:0] idx_r;
  logic [N-1:0]  shadow_r, spike_r;
  logic          spike_valid_r, busy_r, ready_r, overrun_r;
  logic [DW-1:0] mon_r;

  logic [DW-1:0] vt_r [N];
  logic [DW-1:0] vr_r [N];
  logic [DW-1:0] ib_r [N];
  logic [DW-1:0] b_r  [N];
  logic [7:0]    a_r  [N];
  logic [3:0]    tw_r [N];
  logic [DW-1:0] v_r  [N];
  logic [DW-1:0] w_r  [N];

  logic [NW-1:0] cfg_nrn_s;
  logic [2:0]    cfg_fld_s;
  logic          cfg_we_s, last_s;
  logic [DW-1:0] v_nx_s, w_nx_s;
  logic          spike_s;

  assign cfg_ready   = ready_r;
  assign spike       = spike_r;
  assign spike_valid = spike_valid_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;
  assign mon_data    = mon_r;

  // Config decode; writes to a nonexistent neuron are accepted but dropped.
  always_comb begin
    cfg_nrn_s = cfg_addr[NW+2:3];
    cfg_fld_s = cfg_addr[2:0];
    cfg_we_s  = cfg_valid && (state_r == IDLE) && ({1'b0, cfg_nrn_s} < N_L);
    last_s    = (idx_r == NW'(N - 1));
  end

  adex_update_core #(
    .DW(DW), .FRAC(FRAC), .EL(EL), .VPEAK(VPEAK), .DELTAT(DELTAT),
    .LEAK_SH(LEAK_SH), .DT_SH(DT_SH)
  ) u_core (
    .vt(vt_r[idx_r]), .vreset(vr_r[idx_r]), .ibias(ib_r[idx_r]), .b(b_r[idx_r]),
    .a(a_r[idx_r]), .tauw_sh(tw_r[idx_r]), .v(v_r[idx_r]), .w(w_r[idx_r]),
    .v_next(v_nx_s), .w_next(w_nx_s), .spike(spike_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (tick) state_nx_s = SWEEP; else state_nx_s = IDLE;
      SWEEP:   if (last_s) state_nx_s = DONE; else state_nx_s = SWEEP;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Sweep index, spike shadow, status outputs and monitor.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r         <= {NW{1'b0}};
      shadow_r      <= {N{1'b0}};
      spike_r       <= {N{1'b0}};
      spike_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      ready_r       <= 1'b1;
      overrun_r     <= 1'b0;
      mon_r         <= {DW{1'b0}};
    end else begin
      if (state_r == SWEEP && !last_s) begin
        idx_r <= idx_r + NW'(1);
      end else begin
        idx_r <= {NW{1'b0}};
      end
      if (state_r == IDLE && tick) begin
        shadow_r <= {N{1'b0}};
      end else if (state_r == SWEEP) begin
        shadow_r[idx_r] <= spike_s;
      end
      if (state_r == DONE) begin
        spike_r <= shadow_r;
      end
      spike_valid_r <= (state_r == DONE);
      busy_r        <= (state_nx_s != IDLE);
      ready_r       <= (state_nx_s == IDLE);
      overrun_r     <= overrun_r | (tick && state_r != IDLE);
      if ({1'b0, mon_sel} < N_L) begin
        mon_r <= mon_w ? w_r[mon_sel] : v_r[mon_sel];
      end else begin
        mon_r <= {DW{1'b0}};
      end
    end
  end

  // Per-neuron register file: config writes in IDLE, datapath writeback in SWEEP.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        vt_r[i] <= VT_INIT;
        vr_r[i] <= VRESET_INIT;
        ib_r[i] <= {DW{1'b0}};
        b_r[i]  <= B_INIT;
        a_r[i]  <= A_INIT;
        tw_r[i] <= TAUW_INIT;
        v_r[i]  <= VRESET_INIT;
        w_r[i]  <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_we_s && cfg_nrn_s == NW'(i)) begin
          case (cfg_fld_s)
            F_VT:     vt_r[i] <= cfg_data;
            F_VRESET: vr_r[i] <= cfg_data;
            F_IBIAS:  ib_r[i] <= cfg_data;
            F_B:      b_r[i]  <= cfg_data;
            F_A:      a_r[i]  <= cfg_data[7:0];
            F_TAUW:   tw_r[i] <= cfg_data[3:0];
            F_V:      v_r[i]  <= cfg_data;
            F_W:      w_r[i]  <= cfg_data;
            default:  ;
          endcase
        end else if (state_r == SWEEP && idx_r == NW'(i)) begin
          v_r[i] <= v_nx_s;
          w_r[i] <= w_nx_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_adex_neuron_array.sv
// Self-checking bench for adex_neuron_array (N=5) against an integer-arithmetic
// reference model, plus hand-computed spot checks.
module tb_adex_neuron_array;
  localparam int N    = 5;
  localparam int NW   = 3;
  localparam int EL_I = -17920;
  localparam int VT0  = -12800;
  localparam int VR0  = -16640;

  logic          clk = 1'b0, reset = 1'b1, tick = 1'b0, cfg_valid = 1'b0, mon_w = 1'b0;
  logic [NW+2:0] cfg_addr = '0;
  logic [15:0]   cfg_data = 16'h0;
  logic [NW-1:0] mon_sel = '0;
  logic          cfg_ready, spike_valid, busy, overrun;
  logic [N-1:0]  spike;
  logic [15:0]   mon_data;

  always #5 clk = ~clk;

  adex_neuron_array #(.N(N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .spike(spike), .spike_valid(spike_valid),
    .busy(busy), .overrun(overrun), .mon_sel(mon_sel), .mon_w(mon_w), .mon_data(mon_data)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_vt[N], m_vr[N], m_ib[N], m_b[N], m_a[N], m_tw[N], m_v[N], m_w[N];
  int p_v[N], p_w[N];
  logic [N-1:0] p_spk, e_spike;
  logic e_sv, e_ovr, m_ok = 1'b0;
  logic [15:0] e_mon;
  int phase;   // 0 idle, 1..N sweeping neuron phase-1, N+1 publishing

  function automatic longint fshr(input longint x, input int s);
    longint d, q;
    d = longint'(1) << s;
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    return q;
  endfunction

  function automatic int satf(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic longint wrap24(input longint x);
    longint y;
    y = x % 16777216;
    if (y < 0) y = y + 16777216;
    if (y >= 8388608) y = y - 16777216;
    return y;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_vt[k] = VT0; m_vr[k] = VR0; m_ib[k] = 0; m_b[k] = 0;
      m_a[k] = 0; m_tw[k] = 6; m_v[k] = VR0; m_w[k] = 0;
    end
    phase = 0; e_spike = '0; e_sv = 1'b0; e_ovr = 1'b0; e_mon = 16'h0;
  endtask

  task automatic apply_write(input int n, input int f, input logic [15:0] d);
    int s;
    s = int'($signed(d));
    if (n < N) begin
      case (f)
        0: m_vt[n] = s;
        1: m_vr[n] = s;
        2: m_ib[n] = s;
        3: m_b[n]  = s;
        4: m_a[n]  = int'(d[7:0]);
        5: m_tw[n] = int'(d[3:0]);
        6: m_v[n]  = s;
        default: m_w[n] = s;
      endcase
    end
  endtask

  task automatic neuron_step(input int k, output int nv, output int nw, output logic sp);
    longint v, w, leak, d, e, ex;
    v = m_v[k];
    w = m_w[k];
    if (v >= 0) begin
      sp = 1'b1; nv = m_vr[k]; nw = satf(w + m_b[k]);
    end else begin
      sp = 1'b0;
      leak = fshr(EL_I - v, 4);
      d = v - m_vt[k];
      if (d < 0) ex = 0;
      else begin
        e = fshr(d, 8);
        if (e > 7) e = 7;
        ex = 512 * (longint'(1) << e);
      end
      nv = satf(v + fshr(leak + ex + m_ib[k] - w, 2));
      nw = satf(w + fshr(fshr(wrap24((v - EL_I) * m_a[k]), 8) - w, m_tw[k]));
    end
  endtask

  // Model advances on each rising edge using the inputs driven before it.
  initial begin
    logic [15:0] mon_nx;
    model_reset();
    forever begin
      @(posedge clk);
      mon_nx = (mon_sel < N) ? 16'(mon_w ? m_w[mon_sel] : m_v[mon_sel]) : 16'h0;
      if (reset) begin
        model_reset();
      end else begin
        e_mon = mon_nx;
        e_sv  = 1'b0;
        if (phase == 0) begin
          if (cfg_valid) apply_write(int'(cfg_addr[5:3]), int'(cfg_addr[2:0]), cfg_data);
          if (tick) begin
            for (int k = 0; k < N; k++) neuron_step(k, p_v[k], p_w[k], p_spk[k]);
            phase = 1;
          end
        end else begin
          if (tick) e_ovr = 1'b1;
          if (phase <= N) begin
            m_v[phase-1] = p_v[phase-1];
            m_w[phase-1] = p_w[phase-1];
            phase++;
          end else begin
            e_spike = p_spk;
            e_sv = 1'b1;
            phase = 0;
          end
        end
      end
      m_ok = 1'b1;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      check("spike", 32'(spike), 32'(e_spike));
      check("spike_valid", 32'(spike_valid), 32'(e_sv));
      check("busy", 32'(busy), 32'(phase != 0));
      check("cfg_ready", 32'(cfg_ready), 32'(phase == 0));
      check("overrun", 32'(overrun), 32'(e_ovr));
      check("mon_data", 32'(mon_data), 32'(e_mon));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic peek(input int sel, input logic wsel, output logic [15:0] val);
    @(negedge clk); mon_sel = NW'(sel); mon_w = wsel;
    @(negedge clk); val = mon_data;
  endtask

  task automatic tick_once();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic cfg_write(input int n, input int f, input logic [15:0] d, output int waits);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = {3'(n), 3'(f)}; cfg_data = d; waits = 0;
    while (!cfg_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("cfg_accept", 32'(cfg_ready), 32'd1);
    @(negedge clk); cfg_valid = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [15:0] val;
    int lat, cnt, wt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_spike", 32'(spike), 32'd0);
    for (int s = 0; s < N; s++) begin
      peek(s, 1'b0, val); check("rst_v", 32'(val), 32'h0000BF00);
      peek(s, 1'b1, val); check("rst_w", 32'(val), 32'd0);
    end

    // Default step and spike_valid latency
    @(negedge clk); tick = 1'b1; lat = -1;
    for (int i = 1; i <= N + 4; i++) begin
      @(negedge clk); tick = 1'b0;
      if (spike_valid && lat < 0) lat = i - 1;
    end
    check("sv_latency", 32'(lat), 32'(N + 1));
    peek(0, 1'b0, val); check("step_v0", 32'(val), 32'h0000BEEC);
    peek(4, 1'b0, val); check("step_v4", 32'(val), 32'h0000BEEC);
    peek(3, 1'b1, val); check("step_w3", 32'(val), 32'd0);

    // Forced spike on neuron 2
    cfg_write(2, 6, 16'h0100, wt);
    cfg_write(2, 3, 16'h0080, wt);
    tick_once(); wait_idle();
    check("spike_n2", 32'(spike), 32'h00000004);
    peek(2, 1'b0, val); check("n2_v", 32'(val), 32'h0000BF00);
    peek(2, 1'b1, val); check("n2_w", 32'(val), 32'h00000080);
    peek(1, 1'b0, val); check("n1_v", 32'(val), 32'h0000BED8);

    // Overrun: second tick two cycles after the first
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (spike_valid) cnt++;
    end
    check("overrun_sv_count", 32'(cnt), 32'd1);
    check("overrun_set", 32'(overrun), 32'd1);

    // Write held during a sweep stalls; out-of-range neuron is dropped
    tick_once();
    cfg_write(N + 1, 6, 16'h1234, wt);
    check("cfg_stalled", 32'(wt > 0), 32'd1);
    for (int s = 0; s < N; s++) peek(s, 1'b0, val);

    // Negative V saturation and w decay
    cfg_write(0, 6, 16'h8000, wt);
    cfg_write(0, 7, 16'h7FFF, wt);
    cfg_write(0, 2, 16'h8000, wt);
    tick_once(); wait_idle();
    peek(0, 1'b0, val); check("vsat_neg", 32'(val), 32'h00008000);
    peek(0, 1'b1, val); check("w_decay", 32'(val), 32'h00007DFF);

    // w saturation on spike
    cfg_write(0, 6, 16'h0000, wt);
    cfg_write(0, 7, 16'h7F00, wt);
    cfg_write(0, 3, 16'h7FFF, wt);
    tick_once(); wait_idle();
    check("wsat_spike", 32'(spike[0]), 32'd1);
    peek(0, 1'b0, val); check("wsat_v", 32'(val), 32'h0000BF00);
    peek(0, 1'b1, val); check("wsat_w", 32'(val), 32'h00007FFF);

    // Large Ibias drives neuron 0 to repeated spiking
    cfg_write(0, 2, 16'h7FFF, wt);
    cfg_write(0, 3, 16'h0100, wt);
    cfg_write(0, 7, 16'h0000, wt);
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      tick_once(); wait_idle();
      if (spike[0]) cnt++;
    end
    check("ibias_spiked", 32'(cnt > 0), 32'd1);

    // Reset mid-sweep
    tick_once();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    peek(0, 1'b0, val); check("midrst_v0", 32'(val), 32'h0000BF00);
    peek(0, 1'b1, val); check("midrst_w0", 32'(val), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      tick      = ($urandom_range(0, 5) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_addr  = 6'($urandom);
      cfg_data  = 16'($urandom);
      mon_sel   = 3'($urandom_range(0, N - 1));
      mon_w     = 1'($urandom);
      reset     = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk); tick = 1'b0; cfg_valid = 1'b0; reset = 1'b0;
    repeat (N + 4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adex_neuron_array.md
# adex_neuron_array

Time-multiplexed array of `N` adaptive-exponential integrate-and-fire neurons sharing one update datapath. Each neuron has its own parameter and state registers. It is the parametrised successor to the single-neuron AdEx core: fixed-point width, fraction bits and neuron count are generics. Configuration uses a valid/ready register port instead of the nibble loader, and the datapath is shift-based with no divider. It sits between the TinyTapeout pin wrapper (configuration, tick generator) and the spike/monitor outputs.

## Interface
Parameters:
- `N`, 4: neuron count, ≥1. `NW = max(1, clog2(N))`.
- `DW`, 16: state/parameter width, signed.
- `FRAC`, 8: fraction bits (Q8.8 default).
- `EL`, 16'hBA00: leak reversal, −70.0.
- `VPEAK`, 16'h0000: spike threshold, 0.0.
- `DELTAT`, 16'h0200: exponential slope factor, 2.0.
- `LEAK_SH`, 4: leak conductance shift.
- `DT_SH`, 2: integration-step shift.
- `VT_INIT`, 16'hCE00: per-neuron VT reset value, −50.0.
- `VRESET_INIT`, 16'hBF00: per-neuron Vreset reset value, −65.0.
- `A_INIT`, 0: per-neuron reset value of `a`.
- `B_INIT`, 0: per-neuron reset value of `b`.
- `TAUW_INIT`, 6: per-neuron reset value of `tauw_sh`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle request for one integration step of all neurons.
- `cfg_valid` in 1: configuration write request.
- `cfg_ready` out 1: write accepted on a cycle where valid && ready.
- `cfg_addr` in NW+3: `{neuron, field}`.
- `cfg_data` in DW: write data.
- `spike` out N: spike vector of the last sweep.
- `spike_valid` out 1: one-cycle pulse when `spike` is updated.
- `busy` out 1: sweep in progress.
- `overrun` out 1: sticky flag, a tick arrived while not IDLE.
- `mon_sel` in NW: neuron to monitor.
- `mon_w` in 1: 0 selects V, 1 selects w.
- `mon_data` out DW: registered monitor value.

## Operation
- Per-neuron registers: `VT`, `Vreset`, `Ibias`, `b` (DW each), `a` (8b unsigned), `tauw_sh` (4b), `V`, `w`.
- Reset values: `V=VRESET_INIT`, `w=0`, `Ibias=0`; all other fields take their `*_INIT` parameter.
- Output reset values: `spike=0`, `spike_valid=0`, `busy=0`, `overrun=0`, `mon_data=0`.
- `cfg_ready = (state==IDLE)`.
- Config fields: 0 VT, 1 Vreset, 2 Ibias, 3 b, 4 a (`cfg_data[7:0]`), 5 tauw_sh (`cfg_data[3:0]`), 6 V, 7 w.
- A neuron index ≥N is accepted and ignored.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP on `tick`; `idx` is cleared.
  - SWEEP updates neuron `idx` each cycle. At `idx==N-1` it goes to DONE, otherwise `idx+1`.
  - DONE → IDLE unconditionally.
- `tick` in SWEEP or DONE is ignored and sets `overrun`. Only reset clears `overrun`.
- Per-neuron update. All terms are computed at DW+8 bits; sat() clamps to [−2^(DW−1), 2^(DW−1)−1]; every shift is arithmetic.
  - If `V >= VPEAK`: spike=1, V ← Vreset, w ← sat(w+b).
  - Otherwise: spike=0 and the following terms apply.
  - `leak = (EL−V) >>> LEAK_SH`.
  - `d = V−VT`; `expt = d<0 ? 0 : DELTAT << min(d>>>FRAC, 7)`.
  - V ← sat(V + ((leak + expt + Ibias − w) >>> DT_SH)).
  - `at = ((V−EL)·a) >>> 8`, using the old V.
  - w ← sat(w + ((at − w) >>> tauw_sh)).
  - Both updates use the old V and w.
- Spike bits accumulate in a shadow vector. In DONE the vector is copied to `spike` and `spike_valid` pulses.
- `mon_data` ← V or w of `mon_sel` on every clock, including mid-sweep. It shows post-update values.

## Timing
- Tick sampled high in IDLE at cycle t:
  - SWEEP runs for cycles t+1 … t+N; neuron k's state is written at the end of cycle t+1+k.
  - `spike` and `spike_valid` are registered at the end of cycle t+N+1.
  - IDLE resumes at t+N+2. Maximum tick rate is one per N+2 cycles.
- `busy` is high during SWEEP and DONE.
- `tick` and an accepted write in the same IDLE cycle: the write commits at that edge and the sweep sees the new value.
- `cfg_valid` held while `cfg_ready=0` stalls the write, which is accepted on the first IDLE cycle.
- Reset mid-sweep: all state returns to reset values on the next edge and no `spike_valid` is issued.
- N=1: SWEEP lasts one cycle.

## Structure
- Package `adex_pkg`:
  - Field address localparams (`F_VT` … `F_W`).
  - `sat` function.
  - Default Q8.8 constants (EL, VPEAK, VT, Vreset, DELTAT).
- Sub-module `adex_update_core`: combinational single-neuron datapath. Inputs are params + V/w; outputs are next V, next w, spike.
- Top level holds the FSM, register arrays, config decode and monitor mux.

## Test plan
- Reset with defaults → `V=0xBF00`, `w=0`, `spike=0`, `cfg_ready=1`. `mon_data=0xBF00` for every `mon_sel`.
- Single tick with defaults:
  - Every V becomes `0xBEEC` (leak −80, >>>2 = −20) and w stays 0.
  - `spike_valid` is asserted exactly at t+N+1.
- Write V=0x0100 to neuron 2 and b=0x0080 to neuron 2, then tick → `spike=4'b0100`, V[2]=0xBF00, w[2]=0x0080. Other neurons are unchanged from the default step.
- Tick at t, then again at t+2 → `overrun=1`, only one `spike_valid`. `overrun` persists until reset.
- `cfg_valid` held during a sweep → `cfg_ready=0` until IDLE, then the write is accepted once. A write to neuron index N+1 (N<8) is accepted with no state change.
- Write Ibias=0x7FFF to neuron 0 and tick repeatedly:
  - V saturates without wrap.
  - Spike occurs on the tick after V ≥ 0, with w += b each spike.
  - Assert reset mid-sweep → all values return to reset defaults next cycle.
